// File: rtl/prbs_sync_checker.sv
// Receive-side PRBS checker: self-synchronising LFSR with lock/loss hysteresis and a saturating error count.
// Define ERR_BITCOUNT_EN to count mismatched bits per word instead of mismatched words.
module prbs_sync_checker #(
    parameter int POLY_LENGTH = 7,
    parameter int POLY_TAP    = 6,
    parameter int NBITS       = 8,
    parameter int LOCK_CNT    = 16,
    parameter int LOSS_CNT    = 4,
    parameter int ERRCNT_W    = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic [NBITS-1:0]    DATA_IN,
    input  logic                CNT_CLR,
    output logic                ERR_DETECT,
    output logic                LOCKED,
    output logic [ERRCNT_W-1:0] ERR_COUNT
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);
    localparam logic [GW-1:0]       GOOD_MAX = GW'(LOCK_CNT);
    localparam logic [BW-1:0]       BAD_MAX  = BW'(LOSS_CNT);
    localparam logic [ERRCNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        ST_HUNT,
        ST_LOCKED
    } state_t;

    state_t                  state_q, state_d;
    logic [POLY_LENGTH-1:0]  lfsr_q, lfsr_d;
    logic                    seed_valid_q, seed_valid_d;
    logic [GW-1:0]           good_cnt_q, good_cnt_d;
    logic [BW-1:0]           bad_cnt_q, bad_cnt_d;
    logic                    err_detect_q, err_detect_d;
    logic [ERRCNT_W-1:0]     err_count_q, err_count_d;

    logic [POLY_LENGTH-1:0]  pred_s;
    logic [POLY_LENGTH-1:0]  lfsr_adv;
    logic [NBITS-1:0]        exp_word;
    logic                    word_match;
    logic [ERRCNT_W-1:0]     err_inc;

    // Unroll NBITS LFSR steps: the first generated bit is the earliest bit of the word.
    always_comb begin
        pred_s   = lfsr_q;
        exp_word = '0;
        for (int i = NBITS - 1; i >= 0; i--) begin
            pred_s      = {pred_s[POLY_LENGTH-2:0], pred_s[POLY_LENGTH-1] ^ pred_s[POLY_TAP-1]};
            exp_word[i] = pred_s[0];
        end
        lfsr_adv = pred_s;
    end

    // An all-zero LFSR would predict zeros forever, so it is never allowed to match.
    assign word_match = (DATA_IN == exp_word) && (lfsr_q != '0);

`ifdef ERR_BITCOUNT_EN
    localparam int PW = $clog2(NBITS + 1);
    logic [NBITS-1:0]       diff;
    logic [PW-1:0]          flip_cnt;
    logic [ERRCNT_W+PW-1:0] err_sum;

    assign diff = DATA_IN ^ exp_word;

    always_comb begin
        flip_cnt = '0;
        for (int i = 0; i < NBITS; i++) begin
            flip_cnt = flip_cnt + PW'(diff[i]);
        end
    end

    assign err_sum = {{PW{1'b0}}, err_count_q} + {{ERRCNT_W{1'b0}}, flip_cnt};
    assign err_inc = (err_sum > {{PW{1'b0}}, CNT_MAX}) ? CNT_MAX : err_sum[ERRCNT_W-1:0];
`else
    assign err_inc = (err_count_q == CNT_MAX) ? CNT_MAX : err_count_q + ERRCNT_W'(1);
`endif

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        seed_valid_d = seed_valid_q;
        good_cnt_d   = good_cnt_q;
        bad_cnt_d    = bad_cnt_q;
        err_detect_d = 1'b0;
        err_count_d  = err_count_q;

        if (EN) begin
            case (state_q)
                ST_HUNT: begin
                    if (word_match && seed_valid_q) begin
                        good_cnt_d = good_cnt_q + GW'(1);
                        if (good_cnt_q == GOOD_MAX - GW'(1)) begin
                            state_d   = ST_LOCKED;
                            bad_cnt_d = '0;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                    lfsr_d       = DATA_IN[POLY_LENGTH-1:0];
                    seed_valid_d = 1'b1;
                end
                ST_LOCKED: begin
                    lfsr_d = lfsr_adv;
                    if (!word_match) begin
                        err_detect_d = 1'b1;
                        err_count_d  = err_inc;
                        bad_cnt_d    = bad_cnt_q + BW'(1);
                        // Losing lock restarts the hunt; this word seeds but cannot count as good.
                        if (bad_cnt_q == BAD_MAX - BW'(1)) begin
                            state_d      = ST_HUNT;
                            good_cnt_d   = '0;
                            seed_valid_d = 1'b0;
                            lfsr_d       = DATA_IN[POLY_LENGTH-1:0];
                        end
                    end else begin
                        bad_cnt_d = '0;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        if (CNT_CLR) begin
            err_count_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_HUNT;
            lfsr_q       <= '0;
            seed_valid_q <= 1'b0;
            good_cnt_q   <= '0;
            bad_cnt_q    <= '0;
            err_detect_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            seed_valid_q <= seed_valid_d;
            good_cnt_q   <= good_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
            err_detect_q <= err_detect_d;
            err_count_q  <= err_count_d;
        end
    end

    assign ERR_DETECT = err_detect_q;
    assign LOCKED     = (state_q == ST_LOCKED);
    assign ERR_COUNT  = err_count_q;

endmodule

// File: tb/tb_prbs_sync_checker.sv
// Scoreboard bench for prbs_sync_checker: directed PRBS7 streams with per-cycle expected outputs.
// ERR_COUNT is 4 bits wide here so the saturation case is reachable.
module tb_prbs_sync_checker;

    localparam int N     = 7;
    localparam int T     = 6;
    localparam int NB    = 8;
    localparam int LOCKN = 16;
    localparam int LOSSN = 4;
    localparam int CW    = 4;

`ifdef ERR_BITCOUNT_EN
    localparam int FLIP3_INC = 3;
    localparam int INV_INC   = 8;
`else
    localparam int FLIP3_INC = 1;
    localparam int INV_INC   = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [NB-1:0] data_in;
    logic          cnt_clr;
    logic          err_detect;
    logic          locked;
    logic [CW-1:0] err_count;

    typedef struct {
        logic          det;
        logic          lock;
        logic [CW-1:0] cnt;
        int            tag;
    } exp_t;

    exp_t          sb_q[$];
    int            total = 0;
    int            bad   = 0;
    int            step  = 0;
    logic [N-1:0]  gen_state;
    logic          e_lock;
    logic [CW-1:0] e_cnt;

    always #5 clk = ~clk;

    prbs_sync_checker #(
        .POLY_LENGTH(N),
        .POLY_TAP   (T),
        .NBITS      (NB),
        .LOCK_CNT   (LOCKN),
        .LOSS_CNT   (LOSSN),
        .ERRCNT_W   (CW)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .EN        (en),
        .DATA_IN   (data_in),
        .CNT_CLR   (cnt_clr),
        .ERR_DETECT(err_detect),
        .LOCKED    (locked),
        .ERR_COUNT (err_count)
    );

    task automatic checkOutput(input string name, input int tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s step %0d: got %0d expected %0d", name, tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs; the expected outputs for that cycle are queued after the edge.
    task automatic applyStimulus(input logic v_en, input logic [NB-1:0] v_data, input logic v_clr,
                                 input logic v_det);
        exp_t e;
        @(negedge clk);
        en      = v_en;
        data_in = v_data;
        cnt_clr = v_clr;
        @(posedge clk);
        e.det  = v_det;
        e.lock = e_lock;
        e.cnt  = e_cnt;
        e.tag  = step;
        step++;
        sb_q.push_back(e);
    endtask

    // Transmit-side PRBS7 generator, earliest bit in the MSB.
    task automatic genWord(output logic [NB-1:0] w);
        logic nb;
        w = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            nb        = gen_state[N-1] ^ gen_state[T-1];
            w[i]      = nb;
            gen_state = {gen_state[N-2:0], nb};
        end
    endtask

    task automatic bumpCount(input int inc);
        int s;
        s = int'(e_cnt) + inc;
        e_cnt = (s > (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(s);
    endtask

    task automatic resetCycles();
        @(negedge clk);
        rst    = 1'b1;
        en     = 1'b0;
        e_lock = 1'b0;
        e_cnt  = '0;
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
    endtask

    // Monitor: one scoreboard entry per driven cycle, compared on the falling edge.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput("err_detect", e.tag, 32'(err_detect), 32'(e.det));
                checkOutput("locked", e.tag, 32'(locked), 32'(e.lock));
                checkOutput("err_count", e.tag, 32'(err_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NB-1:0] w;
        rst     = 1'b1;
        en      = 1'b0;
        cnt_clr = 1'b0;
        data_in = '0;
        e_lock  = 1'b0;
        e_cnt   = '0;

        resetCycles();

        $display("[TB] clean stream lock");
        gen_state = 7'h7F;
        for (int k = 1; k <= 17; k++) begin
            genWord(w);
            e_lock = (k == 17);
            applyStimulus(1'b1, w, 1'b0, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            genWord(w);
            applyStimulus(1'b1, w, 1'b0, 1'b0);
        end

        $display("[TB] single-word errors while locked");
        genWord(w);
        bumpCount(1);
        applyStimulus(1'b1, w ^ 8'h08, 1'b0, 1'b1);
        genWord(w);
        applyStimulus(1'b1, w, 1'b0, 1'b0);
        genWord(w);
        bumpCount(FLIP3_INC);
        applyStimulus(1'b1, w ^ 8'h89, 1'b0, 1'b1);
        genWord(w);
        applyStimulus(1'b1, w, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h55, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'hAA, 1'b0, 1'b0);
        genWord(w);
        applyStimulus(1'b1, w, 1'b0, 1'b0);

        genWord(w);
        e_cnt = '0;
        applyStimulus(1'b1, w, 1'b1, 1'b0);

        $display("[TB] loss of lock and relock");
        for (int k = 1; k <= 4; k++) begin
            genWord(w);
            bumpCount(INV_INC);
            e_lock = (k < 4);
            applyStimulus(1'b1, ~w, 1'b0, 1'b1);
        end
        for (int k = 1; k <= 17; k++) begin
            genWord(w);
            e_lock = (k == 17);
            applyStimulus(1'b1, w, 1'b0, 1'b0);
        end

        $display("[TB] clear coincident with error");
        genWord(w);
        e_cnt = '0;
        applyStimulus(1'b1, w ^ 8'h08, 1'b1, 1'b1);
        genWord(w);
        applyStimulus(1'b1, w, 1'b0, 1'b0);

        $display("[TB] saturation");
        for (int k = 0; k < 20; k++) begin
            genWord(w);
            bumpCount(1);
            applyStimulus(1'b1, w ^ 8'h08, 1'b0, 1'b1);
            genWord(w);
            applyStimulus(1'b1, w, 1'b0, 1'b0);
        end

        $display("[TB] asynchronous reset while locked");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_err_detect", step, 32'(err_detect), 32'd0);
        checkOutput("async_rst_locked", step, 32'(locked), 32'd0);
        checkOutput("async_rst_err_count", step, 32'(err_count), 32'd0);
        resetCycles();

        $display("[TB] all-zero input");
        for (int k = 0; k < 100; k++) begin
            applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
        end

        $display("[TB] sparse enable");
        gen_state = 7'h7F;
        for (int k = 1; k <= 17; k++) begin
            genWord(w);
            e_lock = (k == 17);
            applyStimulus(1'b1, w, 1'b0, 1'b0);
            applyStimulus(1'b0, 8'hA5, 1'b0, 1'b0);
            applyStimulus(1'b0, 8'h5A, 1'b0, 1'b0);
        end
        genWord(w);
        bumpCount(1);
        applyStimulus(1'b1, w ^ 8'h08, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'hA5, 1'b0, 1'b0);
        genWord(w);
        applyStimulus(1'b1, w, 1'b0, 1'b0);

        for (int i = 0; i < 5 && sb_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (sb_q.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
